pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the MIPS pipeline. It generalises the fixed 32-bit decode-stage latch to any payload width. It adds a valid bit, a ready/valid handshake with an optional one-entry skid buffer, and hazard-unit stall/flush controls. One instance sits between each pair of stages (F/D, D/E, E/M, M/W), with a flushed-entry counter for debug.

Parameters:
WIDTH, 32, payload width in bits
BUBBLE, {WIDTH{1'b0}}, value driven on out_data when the stage is empty or flushed (NOP encoding)
SKID, 1, 1 = two-entry (main + skid) buffering with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 8, width of the flush drop counter

Ports:
clk  in  1  stage clock; all state updates on negedge clk, matching the existing stage registers
reset  in  1  synchronous, active-high reset, sampled on negedge clk
stall  in  1  hazard unit hold; blocks the downstream transfer and freezes out_valid/out_data
flush  in  1  hazard unit clear; empties the stage and inserts a bubble
in_valid  in  1  upstream has a payload
in_data  in  WIDTH  upstream payload
in_ready  out  1  stage can accept a payload this cycle
out_valid  out  1  out_data holds a real instruction
out_data  out  WIDTH  payload to next stage
out_ready  in  1  next stage can accept
occupancy  out  2  entries held (0, 1, 2)
drop_count  out  CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- Reset (synchronous, highest priority):
  - out_valid=0, out_data=BUBBLE, skid empty, occupancy=0, drop_count=0.
  - in_ready=1 from the first edge after reset; in_data on the reset edge is discarded.
- Transfers:
  - enq = in_valid & in_ready.
  - deq = out_valid & out_ready & ~stall.
- States (SKID=1): EMPTY (occ 0), FULL (occ 1, main only), SKID (occ 2, main + skid).
  - EMPTY: enq -> FULL, main<=in_data. Latency from enq edge to out_data/out_valid is 1 negedge.
  - FULL:
    - enq & deq -> FULL, main<=in_data.
    - deq only -> EMPTY, out_data<=BUBBLE.
    - enq only -> SKID, skid<=in_data.
    - neither -> hold.
  - SKID:
    - deq -> FULL, main<=skid, skid cleared.
    - otherwise hold.
- in_ready (SKID=1): registered, equals (next state != SKID). It is 0 only in SKID. No combinational path from out_ready or stall.
- SKID=0:
  - Only EMPTY/FULL exist.
  - in_ready = ~out_valid | (out_ready & ~stall), combinational.
  - occupancy is never 2.
- stall:
  - Forces deq=0; out_valid and out_data stay frozen.
  - Upstream may still fill an empty skid entry (SKID=1).
- flush (priority over stall, enq and deq; below reset):
  - Next edge: state EMPTY, out_valid=0, out_data=BUBBLE, skid cleared.
  - in_data presented on the flush edge is discarded even if in_valid=1.
  - drop_count += occupancy at the flush edge, saturating at 2^CNT_W-1 (never wraps). Flushing an EMPTY stage adds 0.
  - deq on the flush cycle does not occur; downstream must not consume on that edge.
- Simultaneous events:
  - stall+flush: flush wins.
  - reset+flush: reset wins, drop_count=0.
  - enq+deq in FULL: pass-through with no bubble, sustaining 1 payload per cycle.
- Payload ordering is strictly FIFO; the skid entry always drains before new input reaches main.
- Reset mid-transfer drops both entries without counting them.
- out_data when out_valid=0 is always BUBBLE, never stale data.

Test Plan:
1. Reset, then in_valid=1 with in_data=0x2002000A and out_ready=1 -> out_valid=1, out_data=0x2002000A one negedge later; occupancy=1; in_ready stays 1.
2. Stream 0x11, 0x22, 0x33 with out_ready=1 and no stall -> outputs 0x11, 0x22, 0x33 on consecutive edges, no bubbles.
3. stall=1 for 3 cycles while feeding 0xA1, 0xA2, 0xA3 (SKID=1):
   - out_data held at 0xA1; 0xA2 lands in skid; occupancy=2; in_ready=0; 0xA3 is not accepted.
   - After stall drops: outputs 0xA2 then 0xA3 on consecutive edges.
4. flush with occupancy=2 and in_valid=1 (0xFF) -> next edge out_valid=0, out_data=0x00000000, occupancy=0, drop_count=2; 0xFF never appears at the output.
5. stall=1 and flush=1 together with occupancy=1 -> stage empties, drop_count increments by 1.
6. CNT_W=2, flush a full stage five times -> drop_count saturates at 3. reset=1 asserted together with flush -> drop_count=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid bit, ready/valid handshake, optional
// one-entry skid buffer, hazard stall/flush and a saturating flush-drop counter.
// All state changes on the falling clock edge, like the other stage latches.
module pipe_stage_reg #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               SKID   = 1,
  parameter int               CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_count
);

  // State encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_drop;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_ready;
  logic             w_enq;
  logic             w_deq;

  // Saturating add of the number of discarded entries; never wraps.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    if (s[CNT_W]) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  // Handshake: with the skid buffer in_ready comes straight from a flop;
  // without it, a full stage can accept only while it is draining.
  always_comb begin
    w_in_ready = r_in_ready;
    if (SKID == 0) w_in_ready = ~out_valid | (out_ready & ~stall);
    w_enq = in_valid & w_in_ready;
    w_deq = out_valid & out_ready & ~stall & ~flush;
  end

  // Next-state and next-payload selection; flush overrides every transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_enq) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = in_data;
          end
        end
        ST_FULL: begin
          if (w_enq && w_deq) begin
            w_main_nxt = in_data;
          end else if (w_deq) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE;
          end else if (w_enq && (SKID != 0)) begin
            w_state_nxt = ST_SKID;
            w_skid_nxt  = in_data;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so the skid entry drains before any new input.
          if (w_deq) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = BUBBLE;
          w_skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  // Stage register: reset wins over flush and clears the counter without counting.
  always_ff @(negedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_main     <= BUBBLE;
      r_skid     <= BUBBLE;
      r_in_ready <= 1'b1;
      r_drop     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != ST_SKID);
      if (flush) r_drop <= sat_add(r_drop, occupancy);
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign occupancy  = r_state;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance (CNT_W=8) and one single-entry
// instance (CNT_W=2) driven in parallel, each tracked by a FIFO model.
module tb_pipe_stage_reg;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 0, stall = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;

  logic         a_ir, a_ov, b_ir, b_ov;
  logic [W-1:0] a_od, b_od;
  logic [1:0]   a_occ, b_occ, b_drop;
  logic [7:0]   a_drop;

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_ready(out_ready),
    .occupancy(a_occ), .drop_count(a_drop));

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_ready(out_ready),
    .occupancy(b_occ), .drop_count(b_drop));

  int nchk = 0;
  int nfail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per instance a FIFO of up to 2 (skid) or 1 (no skid) entries.
  int           n[2];
  logic [W-1:0] e[2][2];
  int           cnt[2];
  bit           irr[2];
  int           cmax[2] = '{255, 3};

  function automatic bit m_ir(input int m);
    if (m == 0) return irr[0];
    return (n[1] == 0) || (out_ready && !stall);
  endfunction

  initial begin
    n = '{0, 0};
    cnt = '{0, 0};
    irr = '{1, 1};
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit ir;
      bit dq;
      ir = m_ir(m);
      if (reset) begin
        n[m] = 0; cnt[m] = 0; irr[m] = 1;
      end else if (flush) begin
        cnt[m] = (cnt[m] + n[m] > cmax[m]) ? cmax[m] : cnt[m] + n[m];
        n[m] = 0; irr[m] = 1;
      end else begin
        dq = (n[m] > 0) && out_ready && !stall;
        if (dq) begin
          e[m][0] = e[m][1];
          n[m]--;
        end
        if (in_valid && ir && n[m] < 2) begin
          e[m][n[m]] = in_data;
          n[m]++;
        end
        irr[m] = (n[m] < 2);
      end
    end
  end

  // Every cycle after reset, compare both instances to the model.
  always @(posedge clk) begin
    #3;
    if (chk_en) begin
      chk("a_valid", a_ov, n[0] > 0);
      chk("a_data", a_od, (n[0] > 0) ? e[0][0] : '0);
      chk("a_occ", a_occ, n[0]);
      chk("a_ready", a_ir, m_ir(0));
      chk("a_drop", a_drop, cnt[0]);
      chk("b_valid", b_ov, n[1] > 0);
      chk("b_data", b_od, (n[1] > 0) ? e[1][0] : '0);
      chk("b_occ", b_occ, n[1]);
      chk("b_ready", b_ir, m_ir(1));
      chk("b_drop", b_drop, cnt[1]);
    end
  end

  task automatic tick(input bit r, input bit s, input bit f, input bit v,
                      input logic [W-1:0] d, input bit ordy);
    reset = r; stall = s; flush = f; in_valid = v; in_data = d; out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    @(posedge clk);
    #2;
    tick(1, 0, 0, 1, 32'hDEAD0000, 0);
    tick(1, 0, 0, 0, '0, 0);
    chk_en = 1;
    chk("rst_valid", a_ov, 0);
    chk("rst_data", a_od, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_ready", a_ir, 1);
    chk("rst_drop", a_drop, 0);

    // First payload appears one edge after acceptance.
    tick(0, 0, 0, 1, 32'h2002000A, 1);
    chk("t1_valid", a_ov, 1);
    chk("t1_data", a_od, 32'h2002000A);
    chk("t1_occ", a_occ, 1);
    chk("t1_ready", a_ir, 1);

    // Back-to-back stream with no bubbles.
    tick(0, 0, 0, 1, 32'h11, 1);
    chk("t2_d11", a_od, 32'h11);
    tick(0, 0, 0, 1, 32'h22, 1);
    chk("t2_d22", a_od, 32'h22);
    tick(0, 0, 0, 1, 32'h33, 1);
    chk("t2_d33", a_od, 32'h33);
    chk("t2_b33", b_od, 32'h33);
    tick(0, 0, 0, 0, '0, 1);
    chk("t2_empty_v", a_ov, 0);
    chk("t2_empty_d", a_od, 0);

    // Stall fills the skid entry and blocks further input.
    tick(0, 1, 0, 1, 32'hA1, 1);
    chk("t3_a1", a_od, 32'hA1);
    tick(0, 1, 0, 1, 32'hA2, 1);
    chk("t3_hold", a_od, 32'hA1);
    chk("t3_occ2", a_occ, 2);
    chk("t3_nrdy", a_ir, 0);
    tick(0, 1, 0, 1, 32'hA3, 1);
    chk("t3_hold2", a_od, 32'hA1);
    chk("t3_occ2b", a_occ, 2);
    tick(0, 0, 0, 1, 32'hA3, 1);
    chk("t3_a2", a_od, 32'hA2);
    chk("t3_rdy", a_ir, 1);
    tick(0, 0, 0, 1, 32'hA3, 1);
    chk("t3_a3", a_od, 32'hA3);
    tick(0, 0, 0, 0, '0, 0);
    chk("t3_keep", a_od, 32'hA3);

    // Flush with two entries counts both and discards the flush-edge input.
    tick(0, 0, 0, 1, 32'hB1, 0);
    chk("t4_occ2", a_occ, 2);
    tick(0, 0, 1, 1, 32'hFF, 1);
    chk("t4_valid", a_ov, 0);
    chk("t4_data", a_od, 0);
    chk("t4_occ", a_occ, 0);
    chk("t4_drop", a_drop, 2);
    tick(0, 0, 0, 0, '0, 1);
    chk("t4_noff", a_ov, 0);

    // Flush wins over stall.
    tick(0, 0, 0, 1, 32'hC1, 0);
    tick(0, 1, 1, 0, '0, 1);
    chk("t5_valid", a_ov, 0);
    chk("t5_drop", a_drop, 3);

    // Saturation of the narrow counter, then reset together with flush.
    tick(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1, 32'hD0 + i, 0);
      tick(0, 0, 1, 0, '0, 0);
      chk("t6_bsat", b_drop, (i + 1 > 3) ? 3 : i + 1);
    end
    chk("t6_b3", b_drop, 3);
    chk("t6_a5", a_drop, 5);
    tick(0, 0, 0, 1, 32'hE0, 0);
    tick(1, 0, 1, 1, 32'hE1, 0);
    chk("t6_rst_b", b_drop, 0);
    chk("t6_rst_a", a_drop, 0);
    chk("t6_rst_v", a_ov, 0);
    tick(0, 0, 0, 0, '0, 0);
    chk("t6_rdy", a_ir, 1);

    @(posedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
